// File: rtl/row_window_ctrl.sv
// row_window_ctrl
// Turns a raster pixel stream into 3x3 windows for the downstream kernel.
// Four IMG_WIDTH-deep row stores are filled round-robin. Once three complete
// rows are buffered, the reader walks them in lockstep and emits one window
// per column position. The occupancy count provides backpressure to the source
// and keeps the row being written apart from the three rows being read.
// IMG_WIDTH must be at least 4.

module row_window_ctrl #(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [PIX_W-1:0]   in_pixel,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [9*PIX_W-1:0] out_window,
    output logic               row_done,
    output logic               overflow
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int CNT_W = $clog2(4 * IMG_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(4 * IMG_WIDTH);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(3 * IMG_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ROW   = CNT_W'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Last column of a row, and last column at which a full 3-wide window fits.
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_LAST_WIN = COL_W'(IMG_WIDTH - 3);
    localparam logic [COL_W-1:0] COL_ONE      = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO      = COL_W'(2);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_READ
    } state_t;

    // Row stores, indexed [store][column].
    logic [PIX_W-1:0] row_mem [0:3][0:IMG_WIDTH-1];

    // Write side.
    logic [1:0]       wr_sel;
    logic [COL_W-1:0] wr_col;
    logic             wr_accept;

    // Read side.
    logic [1:0]       rd_sel;
    logic [COL_W-1:0] rd_col;
    logic [1:0]       top_sel;
    logic [1:0]       mid_sel;
    logic [1:0]       bot_sel;
    logic [COL_W-1:0] col_a;
    logic [COL_W-1:0] col_b;
    logic [COL_W-1:0] col_c;
    logic             win_fits;
    logic [9*PIX_W-1:0] window_next;

    // Occupancy and control.
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    state_t           state;
    state_t           state_next;
    logic             read_step;
    logic             end_step;

    // Source handshake: ready while at least one row store slot is free.
    assign in_ready  = (count != CNT_FULL);
    assign wr_accept = in_valid && in_ready;

    // Row store write port; a full buffer blocks writes, so the target store is
    // never one of the three being read.
    // NOTE: the storage array has no reset; stale contents are never exposed
    // because reads only start once count says three fresh rows exist, and a
    // reset branch here would prevent mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            row_mem[wr_sel][wr_col] <= in_pixel;
        end
    end

    // Write pointer: column advances per accepted pixel, store advances per row.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update from the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel <= '0;
            wr_col <= '0;
        end else if (wr_accept) begin
            if (wr_col == COL_LAST) begin
                wr_col <= '0;
                wr_sel <= wr_sel + 2'd1;
            end else begin
                wr_col <= wr_col + COL_ONE;
            end
        end
    end

    // Occupancy next value: +1 per accepted pixel, -IMG_WIDTH per finished row.
    // NOTE: every combinational block assigns its outputs a default first so no
    // path leaves a signal unassigned and infers a latch.
    always_comb begin
        count_next = count;
        if (wr_accept) begin
            count_next = count_next + CNT_ONE;
        end
        if (end_step) begin
            count_next = count_next - CNT_ROW;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Window fetch: three consecutive rows (mod 4) at three consecutive columns.
    // Past the last window position the column offsets are pinned to rd_col so
    // the address stays inside the row even for non-power-of-two widths.
    always_comb begin
        top_sel  = rd_sel;
        mid_sel  = rd_sel + 2'd1;
        bot_sel  = rd_sel + 2'd2;
        win_fits = (rd_col <= COL_LAST_WIN);
        col_a    = rd_col;
        col_b    = win_fits ? (rd_col + COL_ONE) : rd_col;
        col_c    = win_fits ? (rd_col + COL_TWO) : rd_col;
        window_next = {row_mem[top_sel][col_a], row_mem[top_sel][col_b], row_mem[top_sel][col_c],
                       row_mem[mid_sel][col_a], row_mem[mid_sel][col_b], row_mem[mid_sel][col_c],
                       row_mem[bot_sel][col_a], row_mem[bot_sel][col_b], row_mem[bot_sel][col_c]};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and step strobes. A step happens whenever the output
    // register is empty or being drained; the step at the last column ends the row.
    always_comb begin
        state_next = state;
        read_step  = 1'b0;
        end_step   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count >= CNT_START) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                read_step = !out_valid || out_ready;
                if (read_step && (rd_col == COL_LAST)) begin
                    end_step   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read pointer: column advances every step; the row set rotates at row end.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel <= '0;
            rd_col <= '0;
        end else if (read_step) begin
            if (end_step) begin
                rd_col <= '0;
                rd_sel <= rd_sel + 2'd1;
            end else begin
                rd_col <= rd_col + COL_ONE;
            end
        end
    end

    // Output window register: load on producing steps, otherwise hold until
    // the downstream accepts, then drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_window <= '0;
        end else if (read_step) begin
            if (win_fits) begin
                out_valid  <= 1'b1;
                out_window <= window_next;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Status flags: row_done pulses after each end-of-row step; overflow is
    // sticky once a pixel is offered while the buffer is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            row_done <= end_step;
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
